// File: rtl/ram_pkg.sv
// Shared definitions for the burst RAM master: FSM encoding, response FIFO
// sizing and small helpers used by the master and its response FIFO.
package ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Response FIFO depth; the count needs 2 bits to reach 3.
  localparam int RSP_DEPTH = 3;
  localparam int RSP_CNT_W = 2;

  // A read may be issued only if every outstanding beat still fits in the FIFO.
  function automatic logic can_issue(input logic [RSP_CNT_W-1:0] count,
                                     input logic inflight);
    return ({1'b0, count} + {2'b00, inflight}) < 3'(RSP_DEPTH);
  endfunction

  // Circular pointer increment over RSP_DEPTH entries.
  function automatic logic [RSP_CNT_W-1:0] ptr_inc(input logic [RSP_CNT_W-1:0] p);
    return (p == RSP_CNT_W'(RSP_DEPTH - 1)) ? '0 : p + RSP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ram_master_if.sv
// Bundle of the command, write-beat, read-beat and RAM-side signals of the
// burst RAM master. The master modport is the view of the block itself.
interface ram_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output busy,
    output ram_cs, ram_we, ram_oe, ram_address, ram_data_in,
    input  ram_data_out
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  busy,
    input  ram_cs, ram_we, ram_oe, ram_address, ram_data_in,
    output ram_data_out
  );

endinterface

// File: rtl/ram_rsp_fifo.sv
// Three-entry synchronous FIFO holding read data captured from the RAM until
// the read-beat stream accepts it. Push and pop in one cycle keep the count.
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 pop_i,
  output logic [WIDTH-1:0]     data_o,
  output logic [RSP_CNT_W-1:0] count_o,
  output logic                 valid_o
);

  logic [WIDTH-1:0]     mem_q [RSP_DEPTH];
  logic [RSP_CNT_W-1:0] wr_ptr_q;
  logic [RSP_CNT_W-1:0] rd_ptr_q;
  logic [RSP_CNT_W-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != RSP_CNT_W'(RSP_DEPTH)) || do_pop);

  // Data storage: written at the write pointer on every accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + RSP_CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - RSP_CNT_W'(1);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = (count_q != '0);

endmodule

// File: rtl/ram_master.sv
// Burst RAM master: turns write/read burst commands into registered RAM
// strobes, pipelining reads one beat per cycle into a small response FIFO.
module ram_master
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_master_if.master bus
);

  localparam logic [ADDR_WIDTH:0] BEAT_ONE = (ADDR_WIDTH + 1)'(1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   beats_q;
  logic                  ram_cs_q;
  logic                  ram_we_q;
  logic                  ram_oe_q;
  logic [ADDR_WIDTH-1:0] ram_address_q;
  logic [DATA_WIDTH-1:0] ram_data_in_q;
  logic                  inflight_q;
  logic [RSP_CNT_W-1:0]  rsp_count;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  issue;
  logic                  last_beat;

  assign last_beat = (beats_q == BEAT_ONE);
  // Issue only when the FIFO can absorb this beat plus the one still in flight.
  assign issue     = (state_q == ST_READ) && can_issue(rsp_count, inflight_q);

  // Burst FSM with registered RAM strobes; a read in flight keeps the read
  // strobes up for one more cycle at the held address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      beats_q       <= '0;
      ram_cs_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_oe_q      <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      ram_cs_q   <= inflight_q;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= inflight_q;
      inflight_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            beats_q <= {1'b0, bus.cmd_len} + BEAT_ONE;
            state_q <= bus.cmd_write ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          if (bus.wr_valid) begin
            ram_cs_q      <= 1'b1;
            ram_we_q      <= 1'b1;
            ram_oe_q      <= 1'b0;
            ram_address_q <= addr_q;
            ram_data_in_q <= bus.wr_data;
            addr_q        <= addr_q + ADDR_WIDTH'(1);
            beats_q       <= beats_q - BEAT_ONE;
            if (last_beat) state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (issue) begin
            ram_cs_q      <= 1'b1;
            ram_oe_q      <= 1'b1;
            ram_address_q <= addr_q;
            inflight_q    <= 1'b1;
            addr_q        <= addr_q + ADDR_WIDTH'(1);
            beats_q       <= beats_q - BEAT_ONE;
            if (last_beat) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight_q && (rsp_count == '0)) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ram_rsp_fifo #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (bus.ram_data_out),
    .pop_i   (bus.rd_ready),
    .data_o  (rsp_data),
    .count_o (rsp_count),
    .valid_o (rsp_valid)
  );

  assign bus.cmd_ready   = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.wr_ready    = (state_q == ST_WRITE);
  assign bus.rd_valid    = rsp_valid;
  assign bus.rd_data     = rsp_data;
  assign bus.ram_cs      = ram_cs_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_oe      = ram_oe_q;
  assign bus.ram_address = ram_address_q;
  assign bus.ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: behavioural RAM, shadow memory, write-strobe and
// read-data scoreboards, directed burst scenarios.
module tb_ram_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_master_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  ram_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  ram_mem [256];
  logic [7:0]  smem [256];
  logic [7:0]  rexp [$];
  logic [15:0] wexp [$];
  logic [7:0]  wq [$];
  int          pop_cyc [$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  int          lat = -1;
  int          wstrobes = 0;
  int          we_oe_bad = 0;
  logic        first_pend = 1'b0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  // Behavioural RAM: write on strobe, combinational read while read strobes held.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_cs && bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_data_in;
  end
  assign bus.ram_data_out = (bus.ram_cs && !bus.ram_we && bus.ram_oe) ? ram_mem[bus.ram_address] : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bad(input string tag, input string what);
    n_cmp++;
    n_mis++;
    $error("FAIL %s: observed %s, required otherwise", tag, what);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: write strobes, read beats, latency, hold-under-backpressure.
  always @(negedge clk) begin
    if (bus.ram_we && bus.ram_oe) we_oe_bad++;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        hs_cyc = cyc;
        lat = -1;
        first_pend = 1'b1;
      end
      if (bus.ram_cs && bus.ram_we) begin
        wstrobes++;
        if (wexp.size() == 0) bad("wr_strobe", "unexpected write strobe");
        else chk("wr_strobe", {16'h0, bus.ram_address, bus.ram_data_in}, {16'h0, wexp.pop_front()});
      end
      if (bus.rd_valid) begin
        if (first_pend) begin
          lat = cyc - hs_cyc;
          first_pend = 1'b0;
        end
        if (hold_pend) chk("rd_hold", 32'(bus.rd_data), 32'(hold_data));
        if (bus.rd_ready) begin
          hold_pend = 1'b0;
          pop_cyc.push_back(cyc);
          if (rexp.size() == 0) bad("rd_data", "beat with empty scoreboard");
          else chk("rd_data", 32'(bus.rd_data), 32'(rexp.pop_front()));
        end else begin
          hold_pend = 1'b1;
          hold_data = bus.rd_data;
        end
      end else if (hold_pend) begin
        bad("rd_hold", "rd_valid dropped before rd_ready");
        hold_pend = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [7:0] l);
    int b = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    while (!bus.cmd_ready && b < 100) begin
      tick();
      b++;
    end
    if (!bus.cmd_ready) bad("cmd_timeout", "cmd_ready never high");
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a);
    logic [7:0] ad;
    for (int i = 0; i < wq.size(); i++) begin
      ad = a + 8'(i);
      wexp.push_back({ad, wq[i]});
      smem[ad] = wq[i];
    end
    send_cmd(1'b1, a, 8'(wq.size() - 1));
    for (int i = 0; i < wq.size(); i++) begin
      int b = 0;
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[i];
      while (!bus.wr_ready && b < 50) begin
        tick();
        b++;
      end
      if (!bus.wr_ready) bad("wr_timeout", "wr_ready never high");
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    chk("wr_all_strobed", 32'(wexp.size()), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] l, input logic bp);
    int k = 0;
    for (int i = 0; i <= int'(l); i++) rexp.push_back(smem[a + 8'(i)]);
    pop_cyc.delete();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, a, l);
    chk("wr_ready_in_read", 32'(bus.wr_ready), 32'd0);
    while (rexp.size() != 0 && k < 300) begin
      bus.rd_ready = bp ? ((k % 3) == 0) : 1'b1;
      tick();
      k++;
    end
    bus.rd_ready = 1'b1;
    if (rexp.size() != 0) begin
      bad("rd_timeout", "beats missing");
      rexp.delete();
    end
    if (!bp) begin
      chk("rd_first_latency", 32'(lat), 32'd3);
      for (int i = 1; i < pop_cyc.size(); i++)
        chk("rd_beat_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end
    k = 0;
    while (bus.busy && k < 50) begin
      tick();
      k++;
    end
    chk("busy_after_read", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int   b;
    logic cs_seen;
    logic [7:0] ad;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'h00;
      smem[i]    = 8'h00;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_len   = 8'h00;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    bus.rd_ready  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_cs", 32'(bus.ram_cs), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_oe", 32'(bus.ram_oe), 32'd0);
    chk("rst_address", 32'(bus.ram_address), 32'd0);
    chk("rst_data_in", 32'(bus.ram_data_in), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    tick();
    chk("wr_ready_idle", 32'(bus.wr_ready), 32'd0);

    // Write burst 0x10, 4 beats
    wstrobes = 0;
    wq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    do_write(8'h10);
    chk("wr_strobe_count", 32'(wstrobes), 32'd4);
    for (int i = 0; i < 4; i++) chk("ram_after_write", 32'(ram_mem[8'h10 + 8'(i)]), 32'hA0 + 32'(i));

    // Read burst 0x10, 4 beats, rd_ready held high
    do_read(8'h10, 8'd3, 1'b0);

    // Address wrap
    wq = '{8'h01, 8'h02, 8'h03};
    do_write(8'hFE);
    chk("wrap_mem_fe", 32'(ram_mem[8'hFE]), 32'h01);
    chk("wrap_mem_ff", 32'(ram_mem[8'hFF]), 32'h02);
    chk("wrap_mem_00", 32'(ram_mem[8'h00]), 32'h03);
    do_read(8'hFE, 8'd2, 1'b0);

    // Backpressure on an 8-beat read
    wq = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    do_write(8'h30);
    do_read(8'h30, 8'd7, 1'b1);

    // Reset in the second beat of an 8-beat read
    for (int i = 0; i < 8; i++) begin
      ad = 8'h30 + 8'(i);
      rexp.push_back(smem[ad]);
    end
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 8'h30, 8'd7);
    b = 0;
    while (!bus.rd_valid && b < 20) begin
      tick();
      b++;
    end
    if (!bus.rd_valid) bad("rst_mid_read", "no first beat");
    chk("rst_mid_first_beat_seen", 32'(rexp.size()), 32'd8);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_cs", 32'(bus.ram_cs), 32'd0);
    chk("rst_mid_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    rexp.delete();
    rst = 1'b0;
    chk("rst_mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    cs_seen = 1'b0;
    repeat (4) begin
      tick();
      cs_seen = cs_seen | bus.ram_cs | bus.rd_valid;
    end
    chk("rst_mid_quiet", 32'(cs_seen), 32'd0);

    // Read-after-write to the same address
    wq = '{8'h5A};
    do_write(8'h40);
    do_read(8'h40, 8'd0, 1'b0);

    chk("we_oe_exclusive", 32'(we_oe_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
